// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter.
// Three writeback sources (ALU, LSU, debug) share the single register file
// write port. Debug normally has absolute priority. ALU and LSU alternate
// round-robin. A starvation guard lets a pending ALU/LSU request override
// debug once it has been denied STARVE_LIMIT cycles in a row. The write-port
// outputs are registered, so a grant in cycle N appears on rf_w_* in cycle N+1.
//
// Handshake: a transfer happens in any cycle where X_valid && X_ready.
// X_ready is combinational from the current valids and arbiter state. At most
// one ready is high per cycle, and ready is never high without valid. A
// requester holds valid/addr/data stable until it sees ready.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [1:0]        grant_id
);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_ALU  = 2'd1;
  localparam logic [1:0] GNT_LSU  = 2'd2;
  localparam logic [1:0] GNT_DBG  = 2'd3;

  localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

  // rr_lsu high means LSU wins the next ALU/LSU tie.
  logic              rr_lsu;
  logic [3:0]        starve_cnt;
  logic [1:0]        gnt;
  logic              any_req;
  logic              rr_pick_lsu;
  logic              starved;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant decision: starvation override, then debug, then round-robin.
  always_comb begin
    any_req     = alu_valid | lsu_valid;
    rr_pick_lsu = lsu_valid & (~alu_valid | rr_lsu);
    starved     = (starve_cnt == STARVE_MAX);
    gnt         = GNT_NONE;
    if (!rst_n) begin
      gnt = GNT_NONE;
    end else if (starved && any_req) begin
      gnt = rr_pick_lsu ? GNT_LSU : GNT_ALU;
    end else if (dbg_valid) begin
      gnt = GNT_DBG;
    end else if (any_req) begin
      gnt = rr_pick_lsu ? GNT_LSU : GNT_ALU;
    end
  end

  assign alu_ready = (gnt == GNT_ALU);
  assign lsu_ready = (gnt == GNT_LSU);
  assign dbg_ready = (gnt == GNT_DBG);

  // Select the address/data of the granted source.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (gnt)
      GNT_ALU: begin
        sel_addr = alu_addr;
        sel_data = alu_data;
      end
      GNT_LSU: begin
        sel_addr = lsu_addr;
        sel_data = lsu_data;
      end
      GNT_DBG: begin
        sel_addr = dbg_addr;
        sel_data = dbg_data;
      end
      default: begin
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  // Round-robin pointer and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_lsu     <= 1'b1;
      starve_cnt <= '0;
    end else begin
      if (gnt == GNT_ALU) rr_lsu <= 1'b1;
      else if (gnt == GNT_LSU) rr_lsu <= 1'b0;

      if (gnt == GNT_ALU || gnt == GNT_LSU || !any_req) begin
        starve_cnt <= '0;
      end else if (gnt == GNT_DBG && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Registered write port; a write to x0 is consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      grant_id  <= GNT_NONE;
    end else begin
      grant_id <= gnt;
      rf_w_en  <= (gnt != GNT_NONE) && (sel_addr != '0);
      if (gnt != GNT_NONE) begin
        rf_w_addr <= sel_addr;
        rf_w_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-source request queues drive the DUT,
// a behavioural arbitration model predicts readys and write-port outputs.
module tb_regfile_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 4;
  localparam int REQ_W        = ADDR_W + DATA_W;
  localparam int EXP_W        = 1 + 2 + ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              alu_valid, lsu_valid, dbg_valid;
  logic [ADDR_W-1:0] alu_addr, lsu_addr, dbg_addr;
  logic [DATA_W-1:0] alu_data, lsu_data, dbg_data;
  logic              alu_ready, lsu_ready, dbg_ready;
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic [1:0]        grant_id;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data), .grant_id(grant_id)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- request queues and model state ----------------
  logic [REQ_W-1:0] alu_q[$];
  logic [REQ_W-1:0] lsu_q[$];
  logic [REQ_W-1:0] dbg_q[$];
  logic [EXP_W-1:0] exp_q[$];

  int n_cmp;
  int n_fail;

  // Model: who won the last ALU/LSU contest, and how long they have waited.
  bit                m_last_was_alu;
  int                m_denied;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_last_was_alu = 1'b1;   // so the first tie goes to LSU
    m_denied       = 0;
    m_addr         = '0;
    m_data         = '0;
    exp_q.delete();
  endtask

  // Returns 0 none, 1 ALU, 2 LSU, 3 DBG from the arbitration rules.
  function automatic int model_pick(input bit a, input bit l, input bit d);
    int rr;
    if (a && l) rr = m_last_was_alu ? 2 : 1;
    else if (a) rr = 1;
    else if (l) rr = 2;
    else        rr = 0;
    if (m_denied >= STARVE_LIMIT && (a || l)) return rr;
    if (d) return 3;
    return rr;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic run_cycle();
    int               g;
    logic [REQ_W-1:0] req;
    bit               en;
    logic [EXP_W-1:0] e;
    alu_valid = (alu_q.size() != 0);
    lsu_valid = (lsu_q.size() != 0);
    dbg_valid = (dbg_q.size() != 0);
    if (alu_valid) {alu_addr, alu_data} = alu_q[0];
    if (lsu_valid) {lsu_addr, lsu_data} = lsu_q[0];
    if (dbg_valid) {dbg_addr, dbg_data} = dbg_q[0];
    #1;
    g = model_pick(alu_valid, lsu_valid, dbg_valid);
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, g == 1});
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, g == 2});
    chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, g == 3});
    if ((alu_valid || lsu_valid) && g == 3) begin
      if (m_denied < STARVE_LIMIT) m_denied++;
    end else begin
      m_denied = 0;
    end
    if (g == 1) m_last_was_alu = 1'b1;
    if (g == 2) m_last_was_alu = 1'b0;
    en = 1'b0;
    if (g != 0) begin
      case (g)
        1: req = alu_q.pop_front();
        2: req = lsu_q.pop_front();
        default: req = dbg_q.pop_front();
      endcase
      {m_addr, m_data} = req;
      en = (m_addr != 0);
    end
    exp_q.push_back({en, g[1:0], m_addr, m_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rf_w_en",   {31'd0, rf_w_en},   {31'd0, e[EXP_W-1]});
    chk("grant_id",  {30'd0, grant_id},  {30'd0, e[EXP_W-2 -: 2]});
    chk("rf_w_addr", {27'd0, rf_w_addr}, {27'd0, e[DATA_W +: ADDR_W]});
    chk("rf_w_data", rf_w_data, e[DATA_W-1:0]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alu_q.delete(); lsu_q.delete(); dbg_q.delete();
    alu_valid = 0; lsu_valid = 0; dbg_valid = 0;
    alu_addr = '0; lsu_addr = '0; dbg_addr = '0;
    alu_data = '0; lsu_data = '0; dbg_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    do_reset();
    chk("reset_en",   {31'd0, rf_w_en},   32'd0);
    chk("reset_gid",  {30'd0, grant_id},  32'd0);
    chk("reset_addr", {27'd0, rf_w_addr}, 32'd0);
    chk("reset_data", rf_w_data,          32'd0);

    // Round-robin tie: LSU, ALU, LSU, ALU with one write per cycle.
    alu_q.push_back({5'd1, 32'hA1}); alu_q.push_back({5'd3, 32'hA3});
    lsu_q.push_back({5'd2, 32'hB2}); lsu_q.push_back({5'd4, 32'hB4});
    run_cycle(); chk("rr_0", {30'd0, grant_id}, 32'd2);
    run_cycle(); chk("rr_1", {30'd0, grant_id}, 32'd1);
    run_cycle(); chk("rr_2", {30'd0, grant_id}, 32'd2);
    run_cycle(); chk("rr_3", {30'd0, grant_id}, 32'd1);
    chk("rr_3_addr", {27'd0, rf_w_addr}, 32'd3);

    // Single ALU write.
    alu_q.push_back({5'd5, 32'h1234});
    run_cycle();
    chk("alu_en",   {31'd0, rf_w_en},   32'd1);
    chk("alu_addr", {27'd0, rf_w_addr}, 32'd5);
    chk("alu_data", rf_w_data,          32'h1234);
    chk("alu_gid",  {30'd0, grant_id},  32'd1);

    // Idle gap: outputs idle, address/data hold.
    run_cycle(); run_cycle();
    chk("idle_gid",  {30'd0, grant_id},  32'd0);
    chk("idle_addr", {27'd0, rf_w_addr}, 32'd5);
    chk("idle_data", rf_w_data,          32'h1234);

    // x0 write is consumed without enabling the write port.
    lsu_q.push_back({5'd0, 32'hFFFF_FFFF});
    run_cycle();
    chk("x0_en",  {31'd0, rf_w_en},  32'd0);
    chk("x0_gid", {30'd0, grant_id}, 32'd2);

    // Starvation: DBG x4, ALU, DBG.
    for (int i = 0; i < 6; i++) dbg_q.push_back({5'(10 + i), 32'hD000 + 32'(i)});
    alu_q.push_back({5'd7, 32'h77}); alu_q.push_back({5'd8, 32'h88});
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      chk("starve_seq", {30'd0, grant_id}, (i == 4) ? 32'd1 : 32'd3);
    end
    alu_q.delete(); dbg_q.delete();

    // Reset mid-write: outputs and readys drop without a clock edge.
    alu_q.push_back({5'd9, 32'h99}); alu_q.push_back({5'd11, 32'hBB});
    run_cycle();
    chk("pre_rst_en", {31'd0, rf_w_en}, 32'd1);
    alu_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_en",    {31'd0, rf_w_en},   32'd0);
    chk("rst_gid",   {30'd0, grant_id},  32'd0);
    chk("rst_ready", {29'd0, alu_ready, lsu_ready, dbg_ready}, 32'd0);
    do_reset();
    alu_q.push_back({5'd12, 32'hC12});
    lsu_q.push_back({5'd13, 32'hC13});
    run_cycle();
    chk("rst_tie_lsu", {30'd0, grant_id}, 32'd2);
    alu_q.delete(); lsu_q.delete();

    // Random traffic with held requests.
    for (int i = 0; i < 400; i++) begin
      if (alu_q.size() == 0 && $urandom_range(0, 99) < 55)
        alu_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
      if (lsu_q.size() == 0 && $urandom_range(0, 99) < 55)
        lsu_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
      if (dbg_q.size() == 0 && $urandom_range(0, 99) < 60)
        dbg_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Arbitrates the single write port of the 32x32 register file between three writeback sources: ALU result, load/store unit, and debug/test injection. Uses valid/ready handshakes, round-robin between ALU and LSU, absolute debug priority with a starvation guard, and registered write-port outputs. Sits between the execute/memory stages and the register file write port (w_en/w_addr/w_data).

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width (32 registers)
STARVE_LIMIT, 4, consecutive denied cycles of a pending ALU/LSU request before it overrides debug priority (1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request granted this cycle
lsu_valid  input  1  load writeback request
lsu_addr  input  ADDR_W  load destination register
lsu_data  input  DATA_W  load data
lsu_ready  output  1  LSU request granted this cycle
dbg_valid  input  1  debug write request
dbg_addr  input  ADDR_W  debug destination register
dbg_data  input  DATA_W  debug data
dbg_ready  output  1  debug request granted this cycle
rf_w_en  output  1  to register file w_en (registered)
rf_w_addr  output  ADDR_W  to register file w_addr (registered)
rf_w_data  output  DATA_W  to register file w_data (registered)
grant_id  output  2  source of current rf write: 0 none, 1 ALU, 2 LSU, 3 DBG (registered)

Behaviour:
- Reset (rst_n low, async): rf_w_en=0, rf_w_addr=0, rf_w_data=0, grant_id=0, rr_ptr=LSU, starve_cnt=0; *_ready=0 while rst_n low. Reset mid-operation discards any registered write (rf_w_en drops immediately).
- Handshake: transfer when X_valid && X_ready. X_ready is combinational from the current valid inputs and state; at most one ready high per cycle. A requester holds valid/addr/data stable until ready. Ready never asserts without valid.
- Arbitration order per cycle:
  1. If starve_cnt == STARVE_LIMIT and (alu_valid or lsu_valid): grant the round-robin choice between ALU/LSU, ignoring dbg.
  2. Else if dbg_valid: grant DBG.
  3. Else among ALU/LSU: if both valid, grant the one rr_ptr names; if one valid, grant it.
- rr_ptr: after an ALU grant it points to LSU; after an LSU grant, to ALU. Unchanged on DBG grant or idle.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle that alu_valid or lsu_valid is high and DBG is granted; clears on any ALU/LSU grant or when neither is valid.
- Latency: a grant in cycle N puts rf_w_en/addr/data/grant_id in cycle N+1; the register file writes at the edge ending cycle N+1. Full throughput: one write per cycle.
- x0 suppression: a request with addr==0 is granted and consumed normally (ready high, rr_ptr/starve_cnt update), but rf_w_en stays 0 in N+1; grant_id still reports the source.
- No grant in cycle N: rf_w_en=0 and grant_id=0 in N+1; rf_w_addr/rf_w_data hold their previous values.
- No address coalescing: back-to-back writes to the same register from different sources are both issued in grant order; the last one wins.

Test Plan:
- Reset: drive rst_n low mid-write (rf_w_en=1) -> rf_w_en, grant_id, all *_ready go 0 at once; after release, the first ALU/LSU tie goes to LSU.
- Single ALU: alu_valid, addr=5, data=0x1234 in cycle N -> alu_ready=1 in N; in N+1 rf_w_en=1, rf_w_addr=5, rf_w_data=0x1234, grant_id=1.
- Round-robin: ALU and LSU both valid for 4 cycles (distinct addrs 1..4) -> grant sequence LSU, ALU, LSU, ALU; one rf write per cycle.
- Debug starvation: dbg_valid and alu_valid held high, STARVE_LIMIT=4 -> DBG granted 4 cycles, ALU granted cycle 5, DBG granted cycle 6, starve_cnt restarts.
- x0 write: lsu_valid, addr=0, data=0xFFFFFFFF -> lsu_ready=1; in N+1 rf_w_en=0, grant_id=2; register file contents unchanged.
- Idle gap: a request, then 2 idle cycles -> rf_w_en=0 and grant_id=0 for 2 cycles; rf_w_addr/rf_w_data hold the last values.
